// File: rtl/pipe_fwd_chain_pkg.sv
// Shared constants and helpers for the pipeline delay chain and its forwarding lookup.
package pipe_pkg;

  localparam int unsigned PIPE_WIDTH = 32;
  localparam int unsigned PIPE_DEPTH = 3;
  localparam int unsigned PIPE_TAG_W = 5;

  // Register x0 is hard-wired to zero and is never a forwarding source.
  localparam logic [PIPE_TAG_W-1:0] TAG_X0 = '0;

  // Supports chains up to 64 stages deep.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < 64; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_fwd_chain_if.sv
// Bus bundle between the hazard/issue logic (master) and the delay chain (slave).
interface pipe_fwd_chain_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH,
  parameter int DEPTH = PIPE_DEPTH,
  parameter int TAG_W = PIPE_TAG_W
);
  localparam int IDX_W = $clog2(DEPTH);

  logic                         in_valid;
  logic [WIDTH-1:0]             in_data;
  logic [TAG_W-1:0]             in_tag;
  logic                         in_wr;
  logic                         stall;
  logic [DEPTH-1:0]             flush;
  logic [TAG_W-1:0]             lookup_tag;

  logic [DEPTH-1:0]             stage_valid;
  logic [DEPTH-1:0][WIDTH-1:0]  stage_data;
  logic                         out_valid;
  logic [WIDTH-1:0]             out_data;
  logic [TAG_W-1:0]             out_tag;
  logic                         out_wr;
  logic                         hit;
  logic [IDX_W-1:0]             hit_stage;
  logic [WIDTH-1:0]             hit_data;
  logic [IDX_W:0]               occupancy;

  modport master (
    output in_valid, in_data, in_tag, in_wr, stall, flush, lookup_tag,
    input  stage_valid, stage_data, out_valid, out_data, out_tag, out_wr,
    input  hit, hit_stage, hit_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, in_tag, in_wr, stall, flush, lookup_tag,
    output stage_valid, stage_data, out_valid, out_data, out_tag, out_wr,
    output hit, hit_stage, hit_data, occupancy
  );

endinterface

// File: rtl/pipe_fwd_chain_match.sv
// Priority tag comparator: reports the youngest valid, writing stage whose tag equals lookup_tag_i.
module pipe_fwd_match
  import pipe_pkg::*;
#(
  parameter int DEPTH = PIPE_DEPTH,
  parameter int TAG_W = PIPE_TAG_W,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0]             wr_i,
  input  logic [DEPTH-1:0][TAG_W-1:0]  tag_i,
  input  logic [TAG_W-1:0]             lookup_tag_i,
  output logic                         hit_o,
  output logic [IDX_W-1:0]             hit_stage_o
);

  logic [DEPTH-1:0] match_s;
  logic             not_x0_s;

  // Per-stage match vector, then a descending scan so the lowest index wins.
  always_comb begin
    match_s     = '0;
    hit_stage_o = '0;
    not_x0_s    = (lookup_tag_i != TAG_W'(TAG_X0));
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = valid_i[i] & wr_i[i] & (tag_i[i] == lookup_tag_i) & not_x0_s;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hit_stage_o = match_s[i] ? IDX_W'(i) : hit_stage_o;
    end
    hit_o = |match_s;
  end

endmodule

// File: rtl/pipe_fwd_chain.sv
// Pipeline delay chain with per-stage valid, global stall, per-stage flush and forwarding lookup.
module pipe_fwd_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH,
  parameter int DEPTH = PIPE_DEPTH,
  parameter int TAG_W = PIPE_TAG_W
) (
  input  logic            clk,
  input  logic            reset,
  pipe_fwd_chain_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]             valid_s;
  logic [DEPTH-1:0]             wr_s;
  logic [DEPTH-1:0][WIDTH-1:0]  data_s;
  logic [DEPTH-1:0][TAG_W-1:0]  tag_s;
  logic                         hit_s;
  logic [IDX_W-1:0]             hit_stage_s;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             src_valid_s;
    logic             src_wr_s;
    logic [WIDTH-1:0] src_data_s;
    logic [TAG_W-1:0] src_tag_s;
    logic             valid_q, valid_d;
    logic             wr_q, wr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    if (g == 0) begin : g_head
      assign src_valid_s = bus.in_valid;
      assign src_wr_s    = bus.in_wr;
      assign src_data_s  = bus.in_data;
      assign src_tag_s   = bus.in_tag;
    end else begin : g_body
      assign src_valid_s = valid_s[g-1];
      assign src_wr_s    = wr_s[g-1];
      assign src_data_s  = data_s[g-1];
      assign src_tag_s   = tag_s[g-1];
    end

    // Shift or hold; a flush kills the resulting entry but leaves its data/tag in place.
    always_comb begin
      valid_d = valid_q;
      wr_d    = wr_q;
      data_d  = data_q;
      tag_d   = tag_q;
      if (!bus.stall) begin
        valid_d = src_valid_s;
        wr_d    = src_wr_s;
        data_d  = src_data_s;
        tag_d   = src_tag_s;
      end else begin
        valid_d = valid_q;
      end
      if (bus.flush[g]) begin
        valid_d = 1'b0;
        wr_d    = 1'b0;
      end else begin
        wr_d    = wr_d;
      end
    end

    // Stage register; reset overrides stall and flush.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        wr_q    <= 1'b0;
        data_q  <= '0;
        tag_q   <= '0;
      end else begin
        valid_q <= valid_d;
        wr_q    <= wr_d;
        data_q  <= data_d;
        tag_q   <= tag_d;
      end
    end

    assign valid_s[g] = valid_q;
    assign wr_s[g]    = wr_q;
    assign data_s[g]  = data_q;
    assign tag_s[g]   = tag_q;
  end

  pipe_fwd_match #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_match (
    .valid_i      (valid_s),
    .wr_i         (wr_s),
    .tag_i        (tag_s),
    .lookup_tag_i (bus.lookup_tag),
    .hit_o        (hit_s),
    .hit_stage_o  (hit_stage_s)
  );

  assign bus.stage_valid = valid_s;
  assign bus.stage_data  = data_s;
  assign bus.out_valid   = valid_s[DEPTH-1];
  assign bus.out_data    = data_s[DEPTH-1];
  assign bus.out_tag     = tag_s[DEPTH-1];
  assign bus.out_wr      = wr_s[DEPTH-1];
  assign bus.hit         = hit_s;
  assign bus.hit_stage   = hit_stage_s;
  assign bus.hit_data    = hit_s ? data_s[hit_stage_s] : '0;
  assign bus.occupancy   = (IDX_W + 1)'(popcount(64'(valid_s)));

endmodule
